maf_norm: RTL and testbench



---
 rtl/maf_pkg.sv | 40 ++++
 rtl/maf_lzc.sv | 31 +++
 rtl/maf_norm.sv | 211 +++++++++++++++++++++
 tb/tb_maf_norm.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maf_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : maf_pkg                                                           |
// | Brief  : Shared encodings, widths and lane helpers for the MAF normaliser. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package maf_pkg;

    localparam int W_P     = 75;
    localparam int W_LANE  = 36;
    localparam int W_LZC_W = 7;
    localparam int W_LZC_L = 6;

    localparam int WIDE_SIGN = 74;
    localparam int HI_MSB    = 72;
    localparam int HI_LSB    = 37;
    localparam int LO_MSB    = 35;
    localparam int LO_LSB    = 0;

    localparam logic [2:0] CONT_WIDE   = 3'd0;
    localparam logic [2:0] CONT_DUAL   = 3'd1;
    localparam logic [2:0] CONT_NARROW = 3'd2;

    typedef struct packed {
        logic              sign;
        logic [W_LANE-1:0] mag;
    } lane_t;

    // Magnitude of one signed 36-bit lane; -2^35 maps to 2^35 without overflow.
    function automatic lane_t lane_abs(input logic [W_LANE-1:0] f);
        lane_t r;
        r.sign = f[W_LANE-1];
        r.mag  = r.sign ? ((~f) + W_LANE'(1)) : f;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maf_lzc.sv
// +----------------------------------------------------------------------------+
// | Module : maf_lzc                                                           |
// | Brief  : Leading-zero counter; returns W when the input is all zeros.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module maf_lzc #(
    parameter int W  = 36,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_cnt,
    output logic          o_zero
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule

`default_nettype wire

// File: rtl/maf_norm.sv
// +----------------------------------------------------------------------------+
// | Module : maf_norm                                                          |
// | Brief  : Two-stage complement + normalise of the pre-inverter product.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module maf_norm
    import maf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_P-1:0]    p_reg_temp,
    input  logic [2:0]        cont,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_P-1:0]    norm,
    output logic [W_LZC_W-1:0] lzc_w,
    output logic [W_LZC_L-1:0] lzc_hi,
    output logic [W_LZC_L-1:0] lzc_lo,
    output logic              sign_hi,
    output logic              sign_lo,
    output logic              zero_hi,
    output logic              zero_lo,
    output logic              fmt_err
);

    logic adv;

    logic              s1_valid_q,   s1_valid_d;
    logic [2:0]        s1_cont_q,    s1_cont_d;
    logic              s1_sign_hi_q, s1_sign_hi_d;
    logic              s1_sign_lo_q, s1_sign_lo_d;
    logic [W_P-1:0]    s1_mag_q,     s1_mag_d;

    logic              out_valid_q, out_valid_d;
    logic [W_P-1:0]    norm_q,      norm_d;
    logic [W_LZC_W-1:0] lzc_w_q,    lzc_w_d;
    logic [W_LZC_L-1:0] lzc_hi_q,   lzc_hi_d;
    logic [W_LZC_L-1:0] lzc_lo_q,   lzc_lo_d;
    logic              sign_hi_q,   sign_hi_d;
    logic              sign_lo_q,   sign_lo_d;
    logic              zero_hi_q,   zero_hi_d;
    logic              zero_lo_q,   zero_lo_d;
    logic              fmt_err_q,   fmt_err_d;

    lane_t             w_hi;
    lane_t             w_lo;
    logic [W_P-1:0]    w_wide_mag;
    logic [W_LZC_W-1:0] w_cnt_w;
    logic [W_LZC_L-1:0] w_cnt_hi;
    logic [W_LZC_L-1:0] w_cnt_lo;
    logic              w_zero_w;
    logic              w_zero_hi;
    logic              w_zero_lo;
    logic [W_LANE-1:0] w_norm_hi;
    logic [W_LANE-1:0] w_norm_lo;

    // The whole pipe moves together; a stalled output freezes stage 1 as well.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign w_hi       = lane_abs(p_reg_temp[HI_MSB:HI_LSB]);
    assign w_lo       = lane_abs(p_reg_temp[LO_MSB:LO_LSB]);
    assign w_wide_mag = p_reg_temp[WIDE_SIGN] ? ((~p_reg_temp) + W_P'(1)) : p_reg_temp;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_cont_d    = s1_cont_q;
        s1_sign_hi_d = s1_sign_hi_q;
        s1_sign_lo_d = s1_sign_lo_q;
        s1_mag_d     = s1_mag_q;
        if (adv) begin
            s1_valid_d   = in_valid;
            s1_cont_d    = cont;
            s1_sign_hi_d = 1'b0;
            s1_sign_lo_d = 1'b0;
            s1_mag_d     = '0;
            case (cont)
                CONT_WIDE, CONT_NARROW: begin
                    s1_sign_lo_d = p_reg_temp[WIDE_SIGN];
                    s1_mag_d     = w_wide_mag;
                end
                CONT_DUAL: begin
                    s1_sign_hi_d = w_hi.sign;
                    s1_sign_lo_d = w_lo.sign;
                    s1_mag_d     = {2'b00, w_hi.mag, 1'b0, w_lo.mag};
                end
                default: ;
            endcase
        end
    end

    maf_lzc #(.W(W_P)) u_lzc_w (
        .i_data (s1_mag_q),
        .o_cnt  (w_cnt_w),
        .o_zero (w_zero_w)
    );

    maf_lzc #(.W(W_LANE)) u_lzc_hi (
        .i_data (s1_mag_q[HI_MSB:HI_LSB]),
        .o_cnt  (w_cnt_hi),
        .o_zero (w_zero_hi)
    );

    maf_lzc #(.W(W_LANE)) u_lzc_lo (
        .i_data (s1_mag_q[LO_MSB:LO_LSB]),
        .o_cnt  (w_cnt_lo),
        .o_zero (w_zero_lo)
    );

    assign w_norm_hi = s1_mag_q[HI_MSB:HI_LSB] << w_cnt_hi;
    assign w_norm_lo = s1_mag_q[LO_MSB:LO_LSB] << w_cnt_lo;

    always_comb begin
        out_valid_d = out_valid_q;
        norm_d      = norm_q;
        lzc_w_d     = lzc_w_q;
        lzc_hi_d    = lzc_hi_q;
        lzc_lo_d    = lzc_lo_q;
        sign_hi_d   = sign_hi_q;
        sign_lo_d   = sign_lo_q;
        zero_hi_d   = zero_hi_q;
        zero_lo_d   = zero_lo_q;
        fmt_err_d   = fmt_err_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            norm_d      = '0;
            lzc_w_d     = '0;
            lzc_hi_d    = '0;
            lzc_lo_d    = '0;
            sign_hi_d   = 1'b0;
            sign_lo_d   = 1'b0;
            zero_hi_d   = 1'b0;
            zero_lo_d   = 1'b0;
            fmt_err_d   = 1'b0;
            case (s1_cont_q)
                CONT_WIDE, CONT_NARROW: begin
                    // A count of 75 shifts everything out, leaving a zero result.
                    norm_d    = s1_mag_q << w_cnt_w;
                    lzc_w_d   = w_cnt_w;
                    sign_lo_d = s1_sign_lo_q;
                    zero_hi_d = w_zero_w;
                    zero_lo_d = w_zero_w;
                end
                CONT_DUAL: begin
                    norm_d    = {2'b00, w_norm_hi, 1'b0, w_norm_lo};
                    lzc_hi_d  = w_cnt_hi;
                    lzc_lo_d  = w_cnt_lo;
                    sign_hi_d = s1_sign_hi_q;
                    sign_lo_d = s1_sign_lo_q;
                    zero_hi_d = w_zero_hi;
                    zero_lo_d = w_zero_lo;
                end
                default: fmt_err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_cont_q    <= '0;
            s1_sign_hi_q <= 1'b0;
            s1_sign_lo_q <= 1'b0;
            s1_mag_q     <= '0;
            out_valid_q  <= 1'b0;
            norm_q       <= '0;
            lzc_w_q      <= '0;
            lzc_hi_q     <= '0;
            lzc_lo_q     <= '0;
            sign_hi_q    <= 1'b0;
            sign_lo_q    <= 1'b0;
            zero_hi_q    <= 1'b0;
            zero_lo_q    <= 1'b0;
            fmt_err_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cont_q    <= s1_cont_d;
            s1_sign_hi_q <= s1_sign_hi_d;
            s1_sign_lo_q <= s1_sign_lo_d;
            s1_mag_q     <= s1_mag_d;
            out_valid_q  <= out_valid_d;
            norm_q       <= norm_d;
            lzc_w_q      <= lzc_w_d;
            lzc_hi_q     <= lzc_hi_d;
            lzc_lo_q     <= lzc_lo_d;
            sign_hi_q    <= sign_hi_d;
            sign_lo_q    <= sign_lo_d;
            zero_hi_q    <= zero_hi_d;
            zero_lo_q    <= zero_lo_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign norm      = norm_q;
    assign lzc_w     = lzc_w_q;
    assign lzc_hi    = lzc_hi_q;
    assign lzc_lo    = lzc_lo_q;
    assign sign_hi   = sign_hi_q;
    assign sign_lo   = sign_lo_q;
    assign zero_hi   = zero_hi_q;
    assign zero_lo   = zero_lo_q;
    assign fmt_err   = fmt_err_q;

endmodule

`default_nettype wire

// File: tb/tb_maf_norm.sv
// +----------------------------------------------------------------------------+
// | Module : tb_maf_norm                                                       |
// | Brief  : Randomised scoreboard bench for maf_norm against a numeric model. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_maf_norm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [74:0] p_reg_temp;
    logic [2:0]  cont;
    logic        out_valid;
    logic        out_ready;
    logic [74:0] norm;
    logic [6:0]  lzc_w;
    logic [5:0]  lzc_hi;
    logic [5:0]  lzc_lo;
    logic        sign_hi;
    logic        sign_lo;
    logic        zero_hi;
    logic        zero_lo;
    logic        fmt_err;

    always #5 clk = ~clk;

    maf_norm u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .p_reg_temp (p_reg_temp),
        .cont       (cont),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .norm       (norm),
        .lzc_w      (lzc_w),
        .lzc_hi     (lzc_hi),
        .lzc_lo     (lzc_lo),
        .sign_hi    (sign_hi),
        .sign_lo    (sign_lo),
        .zero_hi    (zero_hi),
        .zero_lo    (zero_lo),
        .fmt_err    (fmt_err)
    );

    // rest = {lzc_w, lzc_hi, lzc_lo, sign_hi, sign_lo, zero_hi, zero_lo, fmt_err}
    typedef struct packed {
        logic [74:0] norm;
        logic [23:0] rest;
    } res_t;

    res_t exp_q[$];
    res_t got;
    res_t held;
    res_t e;
    bit   hold_chk = 1'b0;
    bit   done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Signed lane value, magnitude, then shift left until the top bit is set.
    function automatic void lane_ref(input logic [35:0] f, output logic [35:0] nm,
                                     output logic [5:0] cnt, output logic sg, output logic z);
        longint v;
        longint a;
        v   = longint'($signed(f));
        a   = (v < 0) ? -v : v;
        nm  = a[35:0];
        sg  = (v < 0);
        z   = (a == 0);
        cnt = 6'd0;
        while (cnt < 6'd36 && !nm[35]) begin
            nm  = nm << 1;
            cnt = cnt + 6'd1;
        end
    endfunction

    function automatic res_t model(input logic [74:0] p, input logic [2:0] c);
        res_t        r;
        logic [74:0] m;
        int          n;
        logic [35:0] nh, nl;
        logic [5:0]  ch, cl;
        logic        sh, sl, zh, zl;
        r = '0;
        if (c == 3'd0 || c == 3'd2) begin
            m  = p[74] ? (75'd0 - p) : p;
            zl = (m == 75'd0);
            n  = 0;
            while (n < 75 && !m[74]) begin
                m = m << 1;
                n++;
            end
            r.norm = m;
            r.rest = {7'(n), 6'd0, 6'd0, 1'b0, p[74], zl, zl, 1'b0};
        end else if (c == 3'd1) begin
            lane_ref(p[72:37], nh, ch, sh, zh);
            lane_ref(p[35:0], nl, cl, sl, zl);
            r.norm = {2'b00, nh, 1'b0, nl};
            r.rest = {7'd0, ch, cl, sh, sl, zh, zl, 1'b0};
        end else begin
            r.rest = 24'd1;
        end
        return r;
    endfunction

    function automatic logic [74:0] rand_p();
        logic [95:0] raw;
        logic [74:0] r;
        raw = {$urandom, $urandom, $urandom};
        r   = raw[74:0];
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = 75'd1 << 74;
            3: r = r >> $urandom_range(0, 74);
            4: r = ~(r >> $urandom_range(0, 74));
            5: begin
                r[72:37] = 36'h800000000;
                r[35:0]  = '0;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] rand_cont();
        int s;
        s = $urandom_range(0, 9);
        if (s < 3)      return 3'd0;
        else if (s < 6) return 3'd1;
        else if (s < 8) return 3'd2;
        else            return 3'($urandom_range(3, 7));
    endfunction

    // Scoreboard: pop before push so an item never matches in its own accept cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            got.norm = norm;
            got.rest = {lzc_w, lzc_hi, lzc_lo, sign_hi, sign_lo, zero_hi, zero_lo, fmt_err};
            check_eq("in_ready", in_ready, !out_valid || out_ready);
            if (hold_chk) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_norm", got.norm, held.norm);
                check_eq("hold_flags", got.rest, held.rest);
            end
            hold_chk = out_valid && !out_ready;
            held     = got;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("norm", got.norm, e.norm);
                    check_eq("flags", got.rest, e.rest);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(p_reg_temp, cont));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [74:0] p, input logic [2:0] c);
        int w;
        w          = 0;
        in_valid   = 1'b1;
        p_reg_temp = p;
        cont       = c;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        p_reg_temp = '0;
        cont       = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_norm", norm, 75'd0);
        check_eq("rst_flags", {lzc_w, lzc_hi, lzc_lo, sign_hi, sign_lo, zero_hi, zero_lo, fmt_err}, 24'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        // Single transaction: latency and the smallest positive value.
        send(75'd1, 3'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check_eq("lat_cycle2", out_valid, 1'b1);
        check_eq("one_norm", norm, 75'd1 << 74);
        check_eq("one_lzc", lzc_w, 7'd74);
        check_eq("one_sign", sign_lo, 1'b0);
        @(posedge clk);
        #1;

        // Boundary vectors through the scoreboard.
        send('1, 3'd0);
        send(75'd1 << 74, 3'd0);
        send({2'b00, 36'hFFFFFFFFD, 1'b0, 36'd0}, 3'd1);
        send({2'b11, 36'h800000000, 1'b1, 36'h7FFFFFFFF}, 3'd1);
        send(75'h12345, 3'd5);
        send('0, 3'd0);
        send('0, 3'd1);
        send(75'h3FFFFFF, 3'd2);
        in_valid = 1'b0;
        drain();

        // Four back-to-back inputs with the consumer stalled for three cycles.
        fork
            begin
                for (int k = 0; k < 4; k++) send(rand_p(), rand_cont());
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two results in flight.
        out_ready = 1'b0;
        send(rand_p(), 3'd0);
        send(rand_p(), 3'd1);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_norm", norm, 75'd0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(75'd1 << 40, 3'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("relat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check_eq("relat_cycle2", out_valid, 1'b1);
        @(posedge clk);
        #1;
        drain();

        // Random traffic with random backpressure.
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(rand_p(), rand_cont());
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
